// File: rtl/env_gen.sv
// env_gen: gated ADSR envelope generator for one FM operator.
// Output is a log-domain attenuation word. Zero means full level and all-ones means silence.
// Attack is exponential toward zero. Decay and release are linear toward silence.
module env_gen #(
  parameter int asz = 9,
  parameter int csz = 14
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ena,
  input  logic           gate,
  input  logic [3:0]     attack_rate,
  input  logic [3:0]     decay_rate,
  input  logic [3:0]     sustain_lvl,
  input  logic [3:0]     release_rate,
  output logic [asz-1:0] atten,
  output logic [2:0]     state,
  output logic           busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

  localparam logic [csz:0] CNT_ONE_W = {{csz{1'b0}}, 1'b1};
  localparam logic [csz-1:0] CNT_ONE = {{(csz-1){1'b0}}, 1'b1};
  localparam logic [asz:0] LVL_ONE_W = {{asz{1'b0}}, 1'b1};
  localparam logic [asz-1:0] LVL_ONE = {{(asz-1){1'b0}}, 1'b1};

  env_state_t     cur_st, nxt_st;
  logic [asz-1:0] atten_r, nxt_atten;
  logic [csz-1:0] cnt;
  logic           gate_q;
  logic           busy_r;
  logic           rise, fall;
  logic           tick_a, tick_d, tick_r;
  logic [asz-1:0] target;
  logic [asz-1:0] att_step;

  // Rate r ticks when the low (15-r) prescaler bits are all zero; rate 0 never ticks.
  function automatic logic rate_tick(input logic [3:0] r, input logic [csz-1:0] c);
    logic [csz:0] one_hot;
    logic [csz:0] mask;
    if (r == 4'd0) return 1'b0;
    one_hot = CNT_ONE_W << (5'd15 - {1'b0, r});
    mask    = one_hot - CNT_ONE_W;
    return (c & mask[csz-1:0]) == '0;
  endfunction

  // Subtract with a one-bit-wider intermediate so the result clamps at zero.
  function automatic logic [asz-1:0] sat_sub(input logic [asz-1:0] a, input logic [asz-1:0] b);
    logic [asz:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[asz] ? '0 : d[asz-1:0];
  endfunction

  // Increment with a one-bit-wider intermediate so the result clamps at silence.
  function automatic logic [asz-1:0] sat_inc(input logic [asz-1:0] a);
    logic [asz:0] s;
    s = {1'b0, a} + LVL_ONE_W;
    return s[asz] ? '1 : s[asz-1:0];
  endfunction

  assign rise     = gate & ~gate_q;
  assign fall     = ~gate & gate_q;
  assign tick_a   = ena & rate_tick(attack_rate, cnt);
  assign tick_d   = ena & rate_tick(decay_rate, cnt);
  assign tick_r   = ena & rate_tick(release_rate, cnt);
  assign target   = {sustain_lvl, {(asz-4){1'b0}}};
  assign att_step = (atten_r >> 4) + LVL_ONE;

  // Registered state, level, prescaler and gate history; reset parks at silence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      gate_q  <= 1'b0;
      cur_st  <= ST_IDLE;
      atten_r <= '1;
      busy_r  <= 1'b0;
    end else begin
      if (ena) cnt <= cnt + CNT_ONE;
      gate_q  <= gate;
      cur_st  <= nxt_st;
      atten_r <= nxt_atten;
      busy_r  <= (nxt_st != ST_IDLE);
    end
  end

  // Next state and level: gate edges win over level steps, so an edge clk never steps.
  always_comb begin
    nxt_st    = cur_st;
    nxt_atten = atten_r;
    if (rise) begin
      nxt_st = ST_ATTACK;
      if (attack_rate == 4'hf) begin
        nxt_atten = '0;
        nxt_st    = ST_DECAY;
      end
    end else if (fall) begin
      if (cur_st == ST_ATTACK || cur_st == ST_DECAY || cur_st == ST_SUSTAIN)
        nxt_st = ST_RELEASE;
    end else begin
      case (cur_st)
        ST_ATTACK: begin
          if (tick_a) begin
            nxt_atten = sat_sub(atten_r, att_step);
            if (nxt_atten == '0) nxt_st = ST_DECAY;
          end
        end
        ST_DECAY: begin
          if (atten_r >= target) nxt_st = ST_SUSTAIN;
          else if (tick_d) nxt_atten = sat_inc(atten_r);
        end
        ST_RELEASE: begin
          if (tick_r) begin
            nxt_atten = sat_inc(atten_r);
            if (nxt_atten == '1) nxt_st = ST_IDLE;
          end
        end
        default: begin
          nxt_st    = cur_st;
          nxt_atten = atten_r;
        end
      endcase
    end
  end

  assign atten = atten_r;
  assign state = cur_st;
  assign busy  = busy_r;

endmodule
